// File: rtl/skee_timer_pkg.sv
// Shared types and default rate constants for the hold-timer block.
package skee_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    localparam int CLK_HZ  = 50000000;
    localparam int TICK_HZ = 10;
    localparam int DEF_DIV = CLK_HZ / TICK_HZ;

endpackage

// File: rtl/skee_tick_gen.sv
// Prescaler: counts 0..DIV-1 and strobes tick on the last count.
module skee_tick_gen #(
    parameter int DIV = 5000000
) (
    input  logic clk,
    input  logic Reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multi_hold_timer.sv
// Multi-channel hold timer with shared prescaler.
// Build option: MULTI_HOLD_TIMER_RETRIGGER_EN lets a trigger in RUN reload.
module multi_hold_timer
    import skee_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4,
    parameter int DIV    = DEF_DIV
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       sense,
    input  logic [CNT_W-1:0]        duration,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] remain,
    output logic                    tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic dur_nz;

    assign dur_nz = |duration;

    skee_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .Reset (Reset),
        .tick  (tick)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e        state_q;
        logic [CNT_W-1:0] rem_q;
        logic             done_q;
        logic             sense_q;
        logic             trig;

        assign trig = sense[i] & ~sense_q;

        always_ff @(posedge clk) begin
            if (Reset) begin
                state_q <= IDLE;
                rem_q   <= '0;
                done_q  <= 1'b0;
                sense_q <= 1'b0;
            end else begin
                sense_q <= sense[i];
                done_q  <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (trig) begin
                            if (dur_nz) begin
                                state_q <= RUN;
                                rem_q   <= duration;
                            end else begin
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
`ifdef MULTI_HOLD_TIMER_RETRIGGER_EN
                        // Retrigger outranks a same-cycle tick or expiry.
                        if (trig) begin
                            if (dur_nz) begin
                                rem_q   <= duration;
                            end else begin
                                state_q <= IDLE;
                                rem_q   <= '0;
                                done_q  <= 1'b1;
                            end
                        end else
`endif
                        if (tick) begin
                            if (rem_q > ONE) begin
                                rem_q   <= rem_q - ONE;
                            end else begin
                                state_q <= IDLE;
                                rem_q   <= '0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign active[i]                  = (state_q == RUN);
        assign done[i]                    = done_q;
        assign remain[i*CNT_W +: CNT_W]   = rem_q;
    end

endmodule

// File: tb/tb_multi_hold_timer.sv
// Directed bench for multi_hold_timer (DIV=4, NUM_CH=4, CNT_W=4).
module tb_multi_hold_timer;

    logic        clk;
    logic        Reset;
    logic [3:0]  sense;
    logic [3:0]  duration;
    logic [3:0]  active;
    logic [3:0]  done;
    logic [15:0] remain;
    logic        tick;

    int checks;
    int errors;
    int pc;

    multi_hold_timer #(
        .NUM_CH (4),
        .CNT_W  (4),
        .DIV    (4)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .sense    (sense),
        .duration (duration),
        .active   (active),
        .done     (done),
        .remain   (remain),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tk: whether the prescaler strobe is high at the coming edge
    task automatic step(output bit tk);
        tk = (pc == 3) && !Reset;
        pc = Reset ? 0 : (pc + 1) % 4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit tk;
        Reset = 1'b1;
        sense = '0;
        duration = '0;
        step(tk);
        step(tk);
        checks++;
        if ({tick, active, done, remain} !== 25'd0) begin
            errors++;
            $display("FAIL reset: got tick=%b act=%b done=%b rem=%h want all 0",
                     tick, active, done, remain);
        end
        Reset = 1'b0;
    endtask

    task automatic test_idle();
        bit tk;
        int nt;
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            step(tk);
            checks++;
            if ({tick, active, done, remain} !== {(pc == 3), 24'd0}) begin
                errors++;
                $display("FAIL idle cyc %0d: got tick=%b act=%b done=%b rem=%h want tick=%b rest 0",
                         i, tick, active, done, remain, (pc == 3));
            end
            if (tick === 1'b1) nt++;
        end
        checks++;
        if (nt != 5) begin
            errors++;
            $display("FAIL idle_ticks: got %0d want 5", nt);
        end
    endtask

    task automatic test_single();
        bit tk;
        bit ea, ed;
        logic [3:0] er;
        int dn;
        duration = 4'd5;
        sense = 4'b0001;
        step(tk);
        sense = '0;
        duration = 4'd9;
        ea = 1; ed = 0; er = 4'd5; dn = 0;
        checks++;
        if ({active, done, remain} !== {4'b0001, 4'b0000, 16'h0005}) begin
            errors++;
            $display("FAIL single_start: got act=%b done=%b rem=%h want 0001 0000 0005",
                     active, done, remain);
        end
        for (int i = 0; i < 40; i++) begin
            step(tk);
            ed = 0;
            if (tk && ea) begin
                if (er > 1) er--;
                else begin er = 0; ea = 0; ed = 1; end
            end
            checks++;
            if ({active, done, remain} !== {3'b0, ea, 3'b0, ed, 12'h0, er}) begin
                errors++;
                $display("FAIL single cyc %0d: got act=%b done=%b rem=%h want act=%b done=%b rem=%h",
                         i, active, done, remain, ea, ed, er);
            end
            if (ed) begin dn++; break; end
        end
        step(tk);
        checks++;
        if (dn != 1 || done !== 4'b0) begin
            errors++;
            $display("FAIL single_done: got pulses=%0d done=%b want 1 and 0000", dn, done);
        end
    endtask

    task automatic test_zero();
        bit tk;
        duration = 4'd0;
        sense = 4'b0100;
        step(tk);
        sense = '0;
        checks++;
        if ({active, done} !== {4'b0000, 4'b0100}) begin
            errors++;
            $display("FAIL zero_pulse: got act=%b done=%b want 0000 0100", active, done);
        end
        step(tk);
        checks++;
        if ({active, done, remain} !== 24'd0) begin
            errors++;
            $display("FAIL zero_after: got act=%b done=%b rem=%h want 0", active, done, remain);
        end
    endtask

    task automatic test_level();
        bit tk;
        bit ea, ed;
        logic [3:0] er;
        int dn;
        duration = 4'd3;
        sense = 4'b0010;
        step(tk);
        ea = 1; ed = 0; er = 4'd3; dn = 0;
        checks++;
        if ({active, remain} !== {4'b0010, 16'h0030}) begin
            errors++;
            $display("FAIL level_start: got act=%b rem=%h want 0010 0030", active, remain);
        end
        for (int i = 0; i < 39; i++) begin
            step(tk);
            ed = 0;
            if (tk && ea) begin
                if (er > 1) er--;
                else begin er = 0; ea = 0; ed = 1; end
            end
            if (ed) dn++;
            checks++;
            if ({active, done, remain} !== {2'b0, ea, 1'b0, 2'b0, ed, 1'b0, 8'h0, er, 4'h0}) begin
                errors++;
                $display("FAIL level cyc %0d: got act=%b done=%b rem=%h want act=%b done=%b rem=%h",
                         i, active, done, remain, ea, ed, er);
            end
        end
        sense = '0;
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL level_pulses: got %0d want 1", dn);
        end
    endtask

    task automatic test_retrig();
        bit tk;
        bit ea, ed;
        logic [3:0] er;
        int dn, nt, want;
        duration = 4'd6;
        sense = 4'b1000;
        step(tk);
        sense = '0;
        ea = 1; ed = 0; er = 4'd6; dn = 0; nt = 0;
        for (int i = 0; i < 40; i++) begin
            if (er == 4'd2) break;
            step(tk);
            if (tk && ea) er--;
            checks++;
            if ({active, remain} !== {4'b1000, er, 12'h0}) begin
                errors++;
                $display("FAIL retrig_pre cyc %0d: got act=%b rem=%h want act=1000 rem=%h",
                         i, active, remain, er);
            end
        end
        sense = 4'b1000;
        step(tk);
        sense = '0;
`ifdef MULTI_HOLD_TIMER_RETRIGGER_EN
        er = 4'd6;
        want = 6;
`else
        if (tk) begin nt = 1; er--; end
        want = 2;
`endif
        checks++;
        if ({active, done, remain} !== {4'b1000, 4'b0000, er, 12'h0}) begin
            errors++;
            $display("FAIL retrig_hit: got act=%b done=%b rem=%h want act=1000 done=0000 rem=%h",
                     active, done, remain, er);
        end
        for (int i = 0; i < 60; i++) begin
            step(tk);
            ed = 0;
            if (tk && ea) begin
                nt++;
                if (er > 1) er--;
                else begin er = 0; ea = 0; ed = 1; end
            end
            checks++;
            if ({active, done, remain} !== {ea, 3'b0, ed, 3'b0, er, 12'h0}) begin
                errors++;
                $display("FAIL retrig cyc %0d: got act=%b done=%b rem=%h want act=%b done=%b rem=%h",
                         i, active, done, remain, ea, ed, er);
            end
            if (ed) begin dn++; break; end
        end
        checks++;
        if (dn != 1 || nt != want) begin
            errors++;
            $display("FAIL retrig_len: got pulses=%0d ticks=%0d want 1 and %0d", dn, nt, want);
        end
    endtask

    task automatic test_reset_mid();
        bit tk;
        bit ea, ed;
        logic [3:0] er;
        int dn;
        duration = 4'd4;
        sense = 4'b1111;
        step(tk);
        sense = '0;
        checks++;
        if ({active, remain} !== {4'b1111, 16'h4444}) begin
            errors++;
            $display("FAIL multi_start: got act=%b rem=%h want 1111 4444", active, remain);
        end
        Reset = 1'b1;
        sense = 4'b1111;
        step(tk);
        Reset = 1'b0;
        sense = '0;
        checks++;
        if ({tick, active, done, remain} !== 25'd0) begin
            errors++;
            $display("FAIL mid_reset: got tick=%b act=%b done=%b rem=%h want all 0",
                     tick, active, done, remain);
        end
        sense = 4'b0001;
        step(tk);
        sense = '0;
        ea = 1; ed = 0; er = 4'd4; dn = 0;
        checks++;
        if ({active, done, remain} !== {4'b0001, 4'b0000, 16'h0004}) begin
            errors++;
            $display("FAIL fresh_start: got act=%b done=%b rem=%h want 0001 0000 0004",
                     active, done, remain);
        end
        for (int i = 0; i < 40; i++) begin
            step(tk);
            ed = 0;
            if (tk && ea) begin
                if (er > 1) er--;
                else begin er = 0; ea = 0; ed = 1; end
            end
            checks++;
            if ({active, done, remain} !== {3'b0, ea, 3'b0, ed, 12'h0, er}) begin
                errors++;
                $display("FAIL fresh cyc %0d: got act=%b done=%b rem=%h want act=%b done=%b rem=%h",
                         i, active, done, remain, ea, ed, er);
            end
            if (ed) begin dn++; break; end
        end
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL fresh_done: got %0d pulses want 1", dn);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc = 0;
        Reset = 1'b1;
        sense = '0;
        duration = '0;
        test_reset();
        test_idle();
        test_single();
        test_zero();
        test_level();
        test_retrig();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
